// File: rtl/edge_pkg.sv
// Shared types for the edge event arbiter: the per-channel detect-mode encoding
// and the arbiter state, plus the edge qualification helper.
package edge_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RISE = 2'b01,
    FALL = 2'b10,
    BOTH = 2'b11
  } edge_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  function automatic logic edge_qualified(input edge_mode_e mode_sel,
                                          input logic       is_rise,
                                          input logic       is_fall);
    return (is_rise && (mode_sel == RISE || mode_sel == BOTH)) ||
           (is_fall && (mode_sel == FALL || mode_sel == BOTH));
  endfunction

endpackage

// File: rtl/edge_detect_cell.sv
// One monitored channel: input history register, mode qualification and the
// pending / edge-type / sticky-overflow bits.
module edge_detect_cell
  import edge_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_din,
  input  logic [1:0] i_mode,
  input  logic       i_ovf_clr,
  input  logic       i_hs,
  output logic       o_pend_next,
  output logic       o_rise_next,
  output logic       o_ovf
);

  logic r_din_q;
  logic r_pend;
  logic r_rise;
  logic r_ovf;

  logic w_rise;
  logic w_fall;
  logic w_qual;
  logic w_drop;

  assign w_rise = i_din & ~r_din_q;
  assign w_fall = ~i_din & r_din_q;
  assign w_qual = edge_qualified(edge_mode_e'(i_mode), w_rise, w_fall);
  assign w_drop = w_qual & r_pend & ~i_hs;

  // Next-state is exported so the arbiter can offer an edge the cycle after it occurs.
  always_comb begin
    o_pend_next = r_pend;
    o_rise_next = r_rise;
    if (w_qual && (!r_pend || i_hs)) begin
      o_pend_next = 1'b1;
      o_rise_next = w_rise;
    end else if (i_hs) begin
      o_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    r_din_q <= i_din;
    if (reset) begin
      r_pend <= 1'b0;
      r_rise <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= o_pend_next;
      r_rise <= o_rise_next;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (i_ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign o_ovf = r_ovf;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: per-channel edge detection feeding a round-robin
// valid/ready event offer.
//   state | meaning
//   IDLE  | nothing pending, evt_valid low
//   OFFER | evt_ch/evt_rise held until the consumer handshakes
module edge_event_arbiter
  import edge_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     din,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic [NUM_CH-1:0]     ovf_clr,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [CW-1:0]         evt_ch,
  output logic                  evt_rise,
  output logic [NUM_CH-1:0]     ovf
);

  arb_state_e        r_state;
  logic              r_valid;
  logic [CW-1:0]     r_ch;
  logic              r_rise;
  logic [CW-1:0]     r_ptr;

  logic              w_hs;
  logic [NUM_CH-1:0] w_hs_vec;
  logic [NUM_CH-1:0] w_pend_next;
  logic [NUM_CH-1:0] w_rise_next;
  logic [CW-1:0]     w_ch_inc;
  logic [CW-1:0]     w_start;
  logic [CW:0]       w_sum;
  logic              w_found;
  logic [CW-1:0]     w_win;

  assign w_hs     = r_valid & evt_ready;
  assign w_ch_inc = (r_ch == CW'(NUM_CH - 1)) ? '0 : r_ch + CW'(1);
  // On a handshake the search must already start past the channel being accepted.
  assign w_start  = (r_state == OFFER) ? w_ch_inc : r_ptr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_hs_vec[c] = w_hs && (r_ch == CW'(c));

    edge_detect_cell u_cell (
      .clk         (clk),
      .reset       (reset),
      .i_din       (din[c]),
      .i_mode      (mode[2*c+1:2*c]),
      .i_ovf_clr   (ovf_clr[c]),
      .i_hs        (w_hs_vec[c]),
      .o_pend_next (w_pend_next[c]),
      .o_rise_next (w_rise_next[c]),
      .o_ovf       (ovf[c])
    );
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = {1'b0, w_start} + (CW+1)'(i);
      if (w_sum >= (CW+1)'(NUM_CH))
        w_sum = w_sum - (CW+1)'(NUM_CH);
      if (!w_found && w_pend_next[w_sum[CW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_rise  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= OFFER;
            r_valid <= 1'b1;
            r_ch    <= w_win;
            r_rise  <= w_rise_next[w_win];
          end
        end
        OFFER: begin
          if (w_hs) begin
            r_ptr <= w_ch_inc;
            if (w_found) begin
              r_ch   <= w_win;
              r_rise <= w_rise_next[w_win];
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid = r_valid;
  assign evt_ch    = r_ch;
  assign evt_rise  = r_rise;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: a vector table of per-cycle inputs and
// the outputs expected after that cycle's clock edge, then multi-cycle sequences.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] din;
  logic [2*N-1:0] mode;
  logic [N-1:0] ovf_clr;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_ch;
  logic         evt_rise;
  logic [N-1:0] ovf;

  int n_checks = 0;
  int n_fail   = 0;

  edge_event_arbiter #(.NUM_CH(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .mode      (mode),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_rise  (evt_rise),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] clr;
    logic       rdy;
    logic       v;
    logic [1:0] ch;
    logic       r;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(input logic rst, input logic [3:0] d, input logic [7:0] m,
                              input logic [3:0] c, input logic rdy, input logic v,
                              input logic [1:0] ch, input logic r, input logic [3:0] o);
    vec_t t;
    t.rst = rst; t.din = d; t.mode = m; t.clr = c; t.rdy = rdy;
    t.v = v; t.ch = ch; t.r = r; t.ovf = o;
    return t;
  endfunction

  task automatic step(input logic rst, input logic [3:0] d, input logic [7:0] m,
                      input logic [3:0] c, input logic rdy);
    reset     = rst;
    din       = d;
    mode      = m;
    ovf_clr   = c;
    evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Channel and polarity only carry meaning while an event is offered.
  task automatic check(input string name, input logic v, input logic [1:0] ch,
                       input logic r, input logic [3:0] o);
    n_checks++;
    if (evt_valid !== v || ovf !== o || (v && (evt_ch !== ch || evt_rise !== r))) begin
      n_fail++;
      $display("FAIL %s: got valid=%b ch=%0d rise=%b ovf=%b, want valid=%b ch=%0d rise=%b ovf=%b",
               name, evt_valid, evt_ch, evt_rise, ovf, v, ch, r, o);
    end
  endtask

  initial begin
    reset = 1'b1; din = '0; mode = '0; ovf_clr = '0; evt_ready = 1'b0;

    // single rising edge on ch0, mode RISE only
    tbl[0]  = mk(1, 4'b0000, 8'h01, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[1]  = mk(1, 4'b0000, 8'h01, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[2]  = mk(0, 4'b0000, 8'h01, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[3]  = mk(0, 4'b0000, 8'h01, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[4]  = mk(0, 4'b0000, 8'h01, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[5]  = mk(0, 4'b0001, 8'h01, 4'b0000, 1, 1, 0, 1, 4'b0000);
    tbl[6]  = mk(0, 4'b0001, 8'h01, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[7]  = mk(0, 4'b0000, 8'h01, 4'b0000, 1, 0, 0, 0, 4'b0000);
    // simultaneous rises on ch1 and ch3 from pointer 0
    tbl[8]  = mk(1, 4'b0000, 8'hFF, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[9]  = mk(0, 4'b0000, 8'hFF, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[10] = mk(0, 4'b1010, 8'hFF, 4'b0000, 1, 1, 1, 1, 4'b0000);
    tbl[11] = mk(0, 4'b1010, 8'hFF, 4'b0000, 1, 1, 3, 1, 4'b0000);
    tbl[12] = mk(0, 4'b1010, 8'hFF, 4'b0000, 1, 0, 0, 0, 4'b0000);
    // overflow on ch2 under backpressure, clear, clear colliding with overflow
    tbl[13] = mk(0, 4'b1110, 8'hFF, 4'b0000, 0, 1, 2, 1, 4'b0000);
    tbl[14] = mk(0, 4'b1010, 8'hFF, 4'b0000, 0, 1, 2, 1, 4'b0100);
    tbl[15] = mk(0, 4'b1010, 8'hFF, 4'b0100, 0, 1, 2, 1, 4'b0000);
    tbl[16] = mk(0, 4'b1110, 8'hFF, 4'b0100, 0, 1, 2, 1, 4'b0100);
    tbl[17] = mk(0, 4'b1110, 8'hFF, 4'b0100, 0, 1, 2, 1, 4'b0000);
    tbl[18] = mk(0, 4'b1110, 8'hFF, 4'b0000, 1, 0, 0, 0, 4'b0000);
    // new ch0 fall during ch0 handshake
    tbl[19] = mk(0, 4'b1111, 8'hFF, 4'b0000, 0, 1, 0, 1, 4'b0000);
    tbl[20] = mk(0, 4'b1110, 8'hFF, 4'b0000, 1, 1, 0, 0, 4'b0000);
    tbl[21] = mk(0, 4'b1110, 8'hFF, 4'b0000, 1, 0, 0, 0, 4'b0000);
    // ch1 mode turned off while pending
    tbl[22] = mk(0, 4'b1100, 8'hFF, 4'b0000, 0, 1, 1, 0, 4'b0000);
    tbl[23] = mk(0, 4'b1100, 8'hF3, 4'b0000, 0, 1, 1, 0, 4'b0000);
    tbl[24] = mk(0, 4'b1110, 8'hF3, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[25] = mk(0, 4'b1100, 8'hF3, 4'b0000, 1, 0, 0, 0, 4'b0000);
    // levels held across reset release, then reset while offering
    tbl[26] = mk(1, 4'b1111, 8'hFF, 4'b0000, 0, 0, 0, 0, 4'b0000);
    tbl[27] = mk(1, 4'b1111, 8'hFF, 4'b0000, 0, 0, 0, 0, 4'b0000);
    tbl[28] = mk(0, 4'b1111, 8'hFF, 4'b0000, 0, 0, 0, 0, 4'b0000);
    tbl[29] = mk(0, 4'b1111, 8'hFF, 4'b0000, 0, 0, 0, 0, 4'b0000);
    tbl[30] = mk(0, 4'b0111, 8'hFF, 4'b0000, 0, 1, 3, 0, 4'b0000);
    tbl[31] = mk(1, 4'b0111, 8'hFF, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[32] = mk(0, 4'b0111, 8'hFF, 4'b0000, 1, 0, 0, 0, 4'b0000);
    tbl[33] = mk(0, 4'b0111, 8'hFF, 4'b0000, 0, 0, 0, 0, 4'b0000);

    for (int i = 0; i < 34; i++) begin
      step(tbl[i].rst, tbl[i].din, tbl[i].mode, tbl[i].clr, tbl[i].rdy);
      check($sformatf("vec%0d", i), tbl[i].v, tbl[i].ch, tbl[i].r, tbl[i].ovf);
    end

    // four edges at once with the consumer stalled: offer must hold steady
    step(0, 4'b1000, 8'hFF, 4'b0000, 0);
    check("stall_first", 1, 0, 0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b1000, 8'hFF, 4'b0000, 0);
      check("stall_hold", 1, 0, 0, 4'b0000);
    end
    step(0, 4'b1000, 8'hFF, 4'b0000, 1);
    check("rr_ch1", 1, 1, 0, 4'b0000);
    step(0, 4'b1000, 8'hFF, 4'b0000, 1);
    check("rr_ch2", 1, 2, 0, 4'b0000);
    step(0, 4'b1000, 8'hFF, 4'b0000, 1);
    check("rr_ch3", 1, 3, 1, 4'b0000);
    step(0, 4'b1000, 8'hFF, 4'b0000, 1);
    check("rr_drain", 0, 0, 0, 4'b0000);

    // move pointer to 2, then ch0 and ch3 together: ch3 first, wrap to ch0
    step(0, 4'b1010, 8'hFF, 4'b0000, 1);
    check("wrap_ch1", 1, 1, 1, 4'b0000);
    step(0, 4'b1010, 8'hFF, 4'b0000, 1);
    check("wrap_idle", 0, 0, 0, 4'b0000);
    step(0, 4'b0011, 8'hFF, 4'b0000, 0);
    check("wrap_ch3", 1, 3, 0, 4'b0000);
    step(0, 4'b0011, 8'hFF, 4'b0000, 1);
    check("wrap_ch0", 1, 0, 1, 4'b0000);
    step(0, 4'b0011, 8'hFF, 4'b0000, 1);
    check("wrap_drain", 0, 0, 0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of monitored input channels (2..8).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port din  input  NUM_CH  monitored levels, synchronous to clk.
REQ-005 SHALL have port mode  input  2*NUM_CH  per-channel detect mode, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both.
REQ-006 SHALL have port ovf_clr  input  NUM_CH  per-channel overflow clear pulse.
REQ-007 SHALL have port evt_valid  output  1  an event is offered.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts the offered event.
REQ-009 SHALL have port evt_ch  output  clog2(NUM_CH)  channel of the offered event.
REQ-010 SHALL have port evt_rise  output  1  1 = rising edge, 0 = falling edge.
REQ-011 SHALL have port ovf  output  NUM_CH  sticky per-channel overflow flags.

Function
REQ-012 SHALL register din each cycle into din_q; channel c has a rise when din[c]=1 and din_q[c]=0, a fall when din[c]=0 and din_q[c]=1.
REQ-013 SHALL qualify detected edges by the current mode; an edge with mode 00 or of the non-selected polarity is discarded.
REQ-014 SHALL, on a qualified edge in cycle k, set pending[c] and record its type at the clock edge ending cycle k; evt_valid SHALL be asserted in cycle k+1 if no other event is offered.
REQ-015 SHALL implement the arbiter FSM with states IDLE and OFFER: IDLE->OFFER when any pending bit is set; OFFER->IDLE on handshake with no other pending; OFFER->OFFER (next winner) on handshake with pending remaining.
REQ-016 SHALL pick the winner round-robin: search starts at the channel after the last accepted one and wraps from NUM_CH-1 to 0.
REQ-017 SHALL hold evt_valid, evt_ch and evt_rise stable from assertion until the cycle with evt_valid=1 and evt_ready=1 (handshake).
REQ-018 SHALL clear pending[c] at the clock edge ending the handshake cycle for channel c.
REQ-019 SHALL, when a qualified edge on c coincides with the handshake of c, keep pending[c] set with the new type (new event wins).
REQ-020 SHALL, when a qualified edge on c occurs while pending[c] is set and not being handshaked, drop the new edge, keep the stored type, and set ovf[c].
REQ-021 SHALL clear ovf[c] on ovf_clr[c]; a simultaneous overflow on c SHALL take priority and leave ovf[c]=1.
REQ-022 SHALL leave pending events deliverable when mode changes to 00; mode affects only new edges.
REQ-023 SHALL deassert evt_valid only by handshake or reset; evt_ready without evt_valid has no effect.

Reset
REQ-024 SHALL, while reset=1, clear pending, types, ovf, the round-robin pointer (next search from channel 0) and enter IDLE; evt_valid=0, evt_ch=0, evt_rise=0, ovf=0.
REQ-025 SHALL load din_q from din in every reset cycle, so a level held across reset release produces no edge.
REQ-026 SHALL discard an event offered mid-handshake when reset asserts; no event is offered in the first cycle after release.

Structure
REQ-027 SHALL place the detect-mode encoding (enum: OFF, RISE, FALL, BOTH) and the arbiter state enum in a shared package edge_pkg.
REQ-028 SHALL instantiate one sub-module edge_detect_cell per channel (din_q register, mode qualification, pending/type/ovf bits); the arbiter FSM and round-robin pointer SHALL live in the top level.

Verification
REQ-029 SHALL cover: mode=01 on ch0, din[0] 0->1 in cycle 5, evt_ready=1 -> evt_valid=1 in cycle 6 with evt_ch=0, evt_rise=1; evt_valid=0 in cycle 7.
REQ-030 SHALL cover: all modes 11, rising edges on ch1 and ch3 in the same cycle, evt_ready=1, pointer at 0 -> ch1 offered then ch3 on consecutive cycles.
REQ-031 SHALL cover: evt_ready=0 with ch2 pending (rise) and a second ch2 fall -> ovf[2]=1, the offered event stays ch2 rise; ovf_clr[2] pulse -> ovf[2]=0.
REQ-032 SHALL cover: handshake of ch0 in the same cycle as a new ch0 fall -> ch0 offered again next cycle with evt_rise=0, ovf[0]=0.
REQ-033 SHALL cover: din=all-ones held through reset release, mode=11 -> no evt_valid; reset asserted while offering -> evt_valid=0 next cycle and pending cleared.
REQ-034 SHALL cover: mode changes to 00 on ch1 while ch1 is pending -> the ch1 event is still delivered; later ch1 edges are ignored.
